// File: rtl/vga_timing_gen_pkg.sv
// Shared types and default 640x480@60 Hz timing for the VGA raster generator.
// With a 100 MHz system clock, CLK_DIV=4 gives the nominal 25 MHz pixel rate.
package vga_pkg;

  // Raster coordinate; both totals must fit in 10 bits.
  typedef logic [9:0] coord_t;

  localparam int CLK_DIV_DEF   = 4;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Active level of h_sync and v_sync (0 = active-low).
  localparam bit SYNC_POL_DEF  = 1'b0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the image memory reader.
// The generator drives through master; consumers observe through slave.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_tick;
  logic   h_sync;
  logic   v_sync;
  logic   DE;
  coord_t x;
  coord_t y;
  logic   line_start;
  logic   frame_start;

  modport master (
    output pix_tick, h_sync, v_sync, DE, x, y, line_start, frame_start
  );

  modport slave (
    input  pix_tick, h_sync, v_sync, DE, x, y, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen_tick.sv
// Pixel-rate divider: div_cnt cycles 0..CLK_DIV-1 and a registered tick follows each wrap.
// The module is pix_tick_gen. The whole divider freezes while en is low.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick_r  <= 1'b0;
    end else if (en) begin
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
      tick_r  <= (div_cnt == LAST);
    end
  end

  // A tick pending when en drops is held, and it is released again on re-enable.
  assign tick = tick_r & en;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick, x/y counters, registered sync/DE decode and start pulses.
// Qualifiers are decoded from next-state counters so they change on the same edge as x/y.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit SYNC_POL  = SYNC_POL_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  vga_timing_gen_if.master         vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so a boundary equal to 1024 cannot alias to 0.
  localparam logic [10:0] H_VIS_B  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG_B = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END_B = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_B  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG_B = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END_B = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic   tick;
  coord_t x_q, y_q, x_nxt, y_nxt;
  logic   de_q, hs_q, vs_q, ls_q, fs_q;
  logic   de_nxt, hs_nxt, vs_nxt;
  logic   hs_act, vs_act;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_nxt = '0;
        y_nxt = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
      end else begin
        x_nxt = x_q + coord_t'(1);
      end
    end

    hs_act = ({1'b0, x_nxt} >= HS_BEG_B) && ({1'b0, x_nxt} < HS_END_B);
    vs_act = ({1'b0, y_nxt} >= VS_BEG_B) && ({1'b0, y_nxt} < VS_END_B);
    de_nxt = ({1'b0, x_nxt} < H_VIS_B) && ({1'b0, y_nxt} < V_VIS_B);
    hs_nxt = hs_act ? SYNC_POL : !SYNC_POL;
    vs_nxt = vs_act ? SYNC_POL : !SYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      de_q <= 1'b1;
      hs_q <= !SYNC_POL;
      vs_q <= !SYNC_POL;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (en) begin
      x_q  <= x_nxt;
      y_q  <= y_nxt;
      de_q <= de_nxt;
      hs_q <= hs_nxt;
      vs_q <= vs_nxt;
      // Pulses mark only the advance edge; any later enabled edge clears them.
      ls_q <= tick && (x_nxt == '0);
      fs_q <= tick && (x_nxt == '0) && (y_nxt == '0);
    end
  end

  assign vga.pix_tick    = tick;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.DE          = de_q;
  assign vga.h_sync      = hs_q;
  assign vga.v_sync      = vs_q;
  assign vga.line_start  = ls_q & en;
  assign vga.frame_start = fs_q & en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced 20x12 raster so several frames fit in a short run.
// Expected outputs come from a closed-form model of the enabled-clock count since reset.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int CD  = 4;
  localparam int HV  = 20, HFP = 3, HS = 5, HBP = 4;
  localparam int VV  = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT  = HV + HFP + HS + HBP;   // 32
  localparam int VT  = VV + VFP + VS + VBP;   // 19
  localparam int FRAME = HT * VT * CD;        // 2432

  typedef struct packed {
    logic       pix_tick;
    logic       h_sync;
    logic       v_sync;
    logic       de;
    logic       line_start;
    logic       frame_start;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  localparam obs_t RESET_OBS = '{pix_tick: 1'b0, h_sync: 1'b1, v_sync: 1'b1, de: 1'b1,
                                 line_start: 1'b0, frame_start: 1'b0, x: 10'd0, y: 10'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned ec = 0;   // enabled clock edges since reset release

  vga_timing_gen_if vif ();

  vga_timing_gen #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .vga   (vif)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec <= 0;
    else if (en) ec <= ec + 1;
  end

  function automatic obs_t sample();
    obs_t o;
    o.pix_tick    = vif.pix_tick;
    o.h_sync      = vif.h_sync;
    o.v_sync      = vif.v_sync;
    o.de          = vif.DE;
    o.line_start  = vif.line_start;
    o.frame_start = vif.frame_start;
    o.x           = vif.x;
    o.y           = vif.y;
    return o;
  endfunction

  // Pixel p has been reached once the (p*CD+1)-th enabled edge has occurred.
  function automatic obs_t model(int unsigned c, logic en_now);
    obs_t o;
    int unsigned p, mx, my;
    logic adv;
    p   = (c == 0) ? 0 : (c - 1) / CD;
    mx  = p % HT;
    my  = (p / HT) % VT;
    adv = (p > 0) && (((c - 1) % CD) == 0);
    o.x           = 10'(mx);
    o.y           = 10'(my);
    o.de          = (mx < HV) && (my < VV);
    o.h_sync      = !((mx >= HV + HFP) && (mx < HV + HFP + HS));
    o.v_sync      = !((my >= VV + VFP) && (my < VV + VFP + VS));
    o.pix_tick    = en_now && (c > 0) && ((c % CD) == 0);
    o.line_start  = en_now && adv && (mx == 0);
    o.frame_start = en_now && adv && (mx == 0) && (my == 0);
    return o;
  endfunction

  task automatic test_reset();
    obs_t got, exp;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    got = sample();
    n_checks++;
    if (got !== RESET_OBS) begin
      n_errors++;
      $display("FAIL reset_state got=%h exp=%h", got, RESET_OBS);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      got = sample();
      exp = model(ec, en);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset_release cycle=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 4 || k == 5) begin
        n_checks++;
        if (got.pix_tick !== (k == 4) || got.x !== 10'(k == 5)) begin
          n_errors++;
          $display("FAIL first_tick cycle=%0d pix_tick=%b x=%0d", k, got.pix_tick, got.x);
        end
      end
    end
  endtask

  task automatic test_hsync();
    obs_t got, exp;
    int hs_low = 0, de_hi = 0, guard = 0;
    do begin
      @(negedge clk);
      got = sample();
      exp = model(ec, en);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL hsync_run ec=%0d got=%h exp=%h", ec, got, exp);
      end
      if (got.y == 10'd1) begin
        if (!got.h_sync) hs_low++;
        if (got.de) de_hi++;
      end
      guard++;
    end while (got.y != 10'd2 && guard < 4 * HT * CD);
    n_checks++;
    if (hs_low != HS * CD || de_hi != HV * CD) begin
      n_errors++;
      $display("FAIL hsync_width hs_low=%0d exp=%0d de_hi=%0d exp=%0d", hs_low, HS * CD, de_hi, HV * CD);
    end
  endtask

  task automatic test_line_wrap();
    obs_t got, exp;
    int guard = 0;
    do begin
      @(negedge clk);
      got = sample();
      exp = model(ec, en);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL line_run ec=%0d got=%h exp=%h", ec, got, exp);
      end
      guard++;
    end while (got.y != 10'd6 && guard < 6 * HT * CD);
    n_checks++;
    if (got.x !== 10'd0 || got.y !== 10'd6 || got.line_start !== 1'b1 || got.frame_start !== 1'b0) begin
      n_errors++;
      $display("FAIL line_wrap x=%0d y=%0d ls=%b fs=%b exp x=0 y=6 ls=1 fs=0",
               got.x, got.y, got.line_start, got.frame_start);
    end
    @(negedge clk);
    got = sample();
    n_checks++;
    if (got.line_start !== 1'b0) begin
      n_errors++;
      $display("FAIL line_pulse_width line_start=%b exp=0", got.line_start);
    end
  endtask

  task automatic test_frame();
    obs_t got, exp;
    int seen = 0, period = 0, vs_low = 0, guard = 0;
    while (seen < 2 && guard < 3 * FRAME) begin
      @(negedge clk);
      got = sample();
      exp = model(ec, en);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL frame_run ec=%0d got=%h exp=%h", ec, got, exp);
      end
      if (seen == 1) begin
        period++;
        if (!got.v_sync) vs_low++;
      end
      if (got.frame_start) begin
        seen++;
        n_checks++;
        if (got.x !== 10'd0 || got.y !== 10'd0 || got.de !== 1'b1 || got.line_start !== 1'b1) begin
          n_errors++;
          $display("FAIL frame_wrap x=%0d y=%0d de=%b ls=%b exp 0 0 1 1",
                   got.x, got.y, got.de, got.line_start);
        end
      end
      guard++;
    end
    n_checks++;
    if (seen != 2 || period != FRAME || vs_low != VS * HT * CD) begin
      n_errors++;
      $display("FAIL frame_period seen=%0d period=%0d exp=%0d vs_low=%0d exp=%0d",
               seen, period, FRAME, vs_low, VS * HT * CD);
    end
  endtask

  task automatic test_enable();
    obs_t got, exp, held;
    int guard = 0;
    do begin
      @(negedge clk);
      got = sample();
      guard++;
    end while (!(got.x == 10'd10 && got.pix_tick) && guard < 2 * FRAME);
    n_checks++;
    if (guard >= 2 * FRAME) begin
      n_errors++;
      $display("FAIL enable_reach timeout x=%0d", got.x);
    end
    held = got;
    held.pix_tick = 1'b0;
    held.line_start = 1'b0;
    held.frame_start = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      got = sample();
      n_checks++;
      if (got !== held) begin
        n_errors++;
        $display("FAIL enable_hold k=%0d got=%h exp=%h", k, got, held);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      got = sample();
      exp = model(ec, en);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL enable_random k=%0d ec=%0d en=%b got=%h exp=%h", k, ec, en, got, exp);
      end
      en = ($urandom_range(0, 3) != 0);
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    obs_t got, exp;
    int guard = 0;
    do begin
      @(negedge clk);
      got = sample();
      guard++;
    end while (!(got.x == 10'd28 && got.y == 10'd15) && guard < 2 * FRAME);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = sample();
    n_checks++;
    if (got !== RESET_OBS) begin
      n_errors++;
      $display("FAIL async_reset got=%h exp=%h", got, RESET_OBS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * HT * CD; k++) begin
      @(negedge clk);
      got = sample();
      exp = model(ec, en);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset_restart k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_line_wrap();
    test_frame();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing: pixel-rate tick, horizontal and vertical counters, sync pulses, display-enable, and pixel coordinates.
- Sits directly upstream of the BMP image memory reader, which uses DE/x/y to form the frame-buffer address and gate RGB output.
- Sync outputs go straight to the VGA connector.
- Defaults give 640x480@60 Hz from a 100 MHz system clock.

Parameters:
- CLK_DIV, 4: system clocks per pixel. Must be ≥1; 1 means the tick is always high.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: active level of h_sync/v_sync (0 = active-low).

Ports:
- clk  input  1  system clock. The only clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable. When low, all timing freezes.
- pix_tick  output  1  one-clk pulse per pixel period.
- h_sync  output  1  horizontal sync.
- v_sync  output  1  vertical sync.
- DE  output  1  high while inside the visible area.
- x  output  10  horizontal count, 0..H_TOTAL-1.
- y  output  10  vertical count, 0..V_TOTAL-1.
- line_start  output  1  one-clk pulse after x wraps to 0.
- frame_start  output  1  one-clk pulse after (x,y) wraps to (0,0).

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL similarly (default 525).
  - Both totals must be ≤1024; x and y are 10-bit unsigned.
- Reset (rst_n low, asynchronous):
  - div_cnt=0, x=0, y=0, pix_tick=0, line_start=0, frame_start=0.
  - DE=1, h_sync=v_sync=!SYNC_POL (inactive).
  - Outputs must be consistent with position (0,0).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 on each clk while en=1.
  - pix_tick is registered: high for exactly one clk, in the cycle after div_cnt reaches CLK_DIV-1.
  - With the defaults, the first pix_tick is high in the 4th clk after rst_n deasserts with en=1.
  - Period is CLK_DIV clks.
- Counter advance: on a rising clk edge where pix_tick=1 and en=1:
  - x increments.
  - At x=H_TOTAL-1, x wraps to 0 and y increments.
  - At y=V_TOTAL-1 together with the x wrap, y wraps to 0.
- Decode alignment:
  - DE, h_sync and v_sync are registered outputs computed from next-state counters.
  - They change on the same edge as x/y. There is no skew between coordinates and qualifiers.
- Decode rules:
  - DE = (x < H_VISIBLE) && (y < V_VISIBLE).
  - h_sync active when H_VISIBLE+H_FP ≤ x < H_VISIBLE+H_FP+H_SYNC. Defaults: 656..751.
  - v_sync active when V_VISIBLE+V_FP ≤ y < V_VISIBLE+V_FP+V_SYNC. Defaults: 490..491.
  - v_sync is purely a function of y, so it transitions at the x-wrap edge.
- Start pulses:
  - line_start is high for exactly one clk, in the cycle immediately after the edge where x wrapped to 0.
  - frame_start is high for exactly one clk after the edge where (x,y) wrapped to (0,0).
  - On a frame wrap, line_start and frame_start are both high in the same cycle.
  - Neither pulse is asserted after reset release; the first frame_start occurs after one full frame.
- en=0:
  - div_cnt, x, y, DE, h_sync, v_sync hold their values.
  - pix_tick, line_start, frame_start are forced to 0.
  - On re-enable, counting resumes from the held div_cnt.
- Reset mid-frame: all state returns immediately (asynchronously) to the reset values above, with no partial pulses.
- Timing: frame period = H_TOTAL*V_TOTAL*CLK_DIV clks; 1,680,000 with defaults.

Decomposition:
- Package vga_pkg holds:
  - typedef coord_t (logic [9:0]).
  - Default 640x480 timing localparams: H/V visible, front porch, sync, back porch, totals.
  - SYNC_POL default.
- One natural sub-module: pix_tick_gen (div_cnt + registered tick, parameter CLK_DIV, with en input). The main block instantiates it.

Test Plan:
- Reset then en=1 → x=0, y=0, DE=1, h_sync=v_sync=1 immediately; pix_tick high in clk 4, 8, 12, …; x=1 after the first tick edge.
- Run to x=655→656 → h_sync falls to 0 on the same edge; it rises back to 1 on the 751→752 edge; DE=0 from x=640 onward.
- Line wrap (x=799, y=5) → next tick edge gives x=0, y=6; line_start high for exactly 1 clk; frame_start stays 0.
- Frame wrap (x=799, y=524) → (0,0), DE=1; frame_start and line_start high together for 1 clk; v_sync is low for exactly 2 lines (y=490,491); the 1,680,000-clk frame period is checked between successive frame_start pulses.
- en dropped for 20 clks at x=300 → x, div_cnt and all outputs hold, no pix_tick; after re-enable the tick spacing continues from the held phase.
- rst_n pulsed low asynchronously mid-tick at x=700, y=491 → outputs immediately become x=0, y=0, DE=1, syncs inactive, pulses 0; normal timing restarts.
